// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle single-ALU datapath: one state per cycle, lw 5 / sw,R,addi 4 / beq,j 3 cycles.
// No backpressure: advances every clock; reset gates all write enables combinationally.
module multicycle_controller #(
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t cur, nxt;
  logic   ir_load, mem_wr, reg_wr, pc_write, branch;

  always_ff @(posedge clock) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt        = FETCH;
    alucontrol = 3'b010;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    ir_load    = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (cur)
      FETCH: begin
        alusrcb  = 2'b01;
        ir_load  = 1'b1;
        pc_write = 1'b1;
        nxt      = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000:            nxt = RTYPEEX;
          6'b000100:            nxt = BEQ;
          6'b001000:            nxt = ENABLE_ADDI ? ADDIEX : FETCH;
          6'b000010:            nxt = JUMP;
          default:              nxt = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        reg_wr   = 1'b1;
      end
      MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        nxt     = ALUWB;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      ALUWB: begin
        regdst = 1'b1;
        reg_wr = 1'b1;
      end
      BEQ: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: reg_wr = 1'b1;
      JUMP: begin
        pcsrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // An instruction interrupted by reset must leave no architectural trace.
  assign irwrite  = ir_load & ~reset;
  assign memwrite = mem_wr & ~reset;
  assign regwrite = reg_wr & ~reset;
  assign pcen     = (pc_write | (branch & zero)) & ~reset;
  assign state    = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed literal checks, then random instruction streams vs an instruction-level model.
module tb_multicycle_controller;

  logic       clock, reset, zero;
  logic [5:0] op, funct;
  logic [2:0] alucontrol, alucontrol0;
  logic       alusrca, iord, memtoreg, regdst, irwrite, memwrite, regwrite, pcen;
  logic       alusrca0, iord0, memtoreg0, regdst0, irwrite0, memwrite0, regwrite0, pcen0;
  logic [1:0] alusrcb, pcsrc, alusrcb0, pcsrc0;
  logic [3:0] state, state0;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_controller dut (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen), .state(state)
  );

  multicycle_controller #(.ENABLE_ADDI(1'b0)) dut0 (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alucontrol0), .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
    .iord(iord0), .memtoreg(memtoreg0), .regdst(regdst0), .irwrite(irwrite0),
    .memwrite(memwrite0), .regwrite(regwrite0), .pcen(pcen0), .state(state0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic       iord, m2r, rdst, irw, mw, rw, pcen;
  } out_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_UNK = 6;

  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_UNK;
    endcase
  endfunction

  // Cycles per instruction, FETCH through its last state.
  function automatic int instr_len(input int c);
    case (c)
      C_LW:          return 5;
      C_SW, C_R, C_ADDI: return 4;
      C_BEQ, C_J:    return 3;
      default:       return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle 'step' of the instruction named by o/f.
  function automatic out_t expect_out(input int step, input logic [5:0] o, input logic [5:0] f,
                                      input logic z, input logic r);
    out_t e;
    int   c;
    e     = '0;
    e.alu = 3'b010;
    c     = classify(o);
    if (step == 0) begin
      e.st = 4'd0; e.asb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1;
    end else if (step == 1) begin
      e.st = 4'd1; e.asb = 2'b11;
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (step == 2) begin e.st = 4'd2; e.asa = 1'b1; e.asb = 2'b10; end
          else if (step == 3 && c == C_LW) begin e.st = 4'd3; e.iord = 1'b1; end
          else if (step == 3) begin e.st = 4'd5; e.iord = 1'b1; e.mw = 1'b1; end
          else begin e.st = 4'd4; e.m2r = 1'b1; e.rw = 1'b1; end
        end
        C_R: begin
          if (step == 2) begin e.st = 4'd6; e.asa = 1'b1; e.alu = funct_alu(f); end
          else begin e.st = 4'd7; e.rdst = 1'b1; e.rw = 1'b1; end
        end
        C_BEQ: begin
          e.st = 4'd8; e.asa = 1'b1; e.alu = 3'b110; e.pcs = 2'b01; e.pcen = z;
        end
        C_ADDI: begin
          if (step == 2) begin e.st = 4'd9; e.asa = 1'b1; e.asb = 2'b10; end
          else begin e.st = 4'd10; e.rw = 1'b1; end
        end
        default: begin e.st = 4'd11; e.pcs = 2'b10; e.pcen = 1'b1; end
      endcase
    end
    if (r) begin
      e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0; e.pcen = 1'b0;
    end
    return e;
  endfunction

  int   m_step  = 0;
  logic m_known = 1'b0;
  logic chk_on  = 1'b1;
  out_t act;

  assign act = {state, alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
                irwrite, memwrite, regwrite, pcen};

  always @(posedge clock) begin
    if (reset) begin
      m_step  <= 0;
      m_known <= 1'b1;
    end else if (m_known) begin
      if (m_step + 1 >= instr_len(classify(op))) m_step <= 0;
      else m_step <= m_step + 1;
    end
  end

  always @(negedge clock) begin
    out_t exp_o;
    if (m_known && chk_on) begin
      exp_o = expect_out(m_step, op, funct, zero, reset);
      n_tests++;
      if (act !== exp_o) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t step=%0d op=%b got=%h want=%h", $time, m_step, op, act, exp_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [5:0] rf_list [3] = '{6'b100010, 6'b101010, 6'b111111};
  logic [2:0] ra_list [3] = '{3'b110, 3'b111, 3'b010};

  initial begin
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_state", state, 4'd0);
      chk("rst_irwrite", irwrite, 1'b0);
      chk("rst_pcen", pcen, 1'b0);
      chk("rst_wr", {memwrite, regwrite}, 2'b00);
    end
    reset = 1'b0;
    #1;
    chk("fetch_irwrite", irwrite, 1'b1);
    chk("fetch_pcen", pcen, 1'b1);
    chk("fetch_alusrcb", alusrcb, 2'b01);
    chk("fetch_alu", alucontrol, 3'b010);

    op = 6'b100011;
    tick(); chk("lw_s1", state, 4'd1);
    tick(); chk("lw_s2", state, 4'd2);
    tick(); chk("lw_s3", state, 4'd3); chk("lw_iord", iord, 1'b1); chk("lw_rw3", regwrite, 1'b0);
    tick(); chk("lw_s4", state, 4'd4);
    chk("lw_wb", {regwrite, memtoreg, regdst}, 3'b110);
    tick(); chk("lw_s0", state, 4'd0);

    for (int i = 0; i < 3; i++) begin
      op = 6'b000000; funct = rf_list[i];
      tick(); chk("r_s1", state, 4'd1);
      tick(); chk("r_s6", state, 4'd6); chk("r_alu", alucontrol, ra_list[i]);
      tick(); chk("r_s7", state, 4'd7); chk("r_wb", {regwrite, regdst}, 2'b11);
      tick(); chk("r_s0", state, 4'd0);
    end

    for (int z = 1; z >= 0; z--) begin
      op = 6'b000100; zero = z[0];
      tick(); chk("beq_s1", state, 4'd1);
      tick(); #1;
      chk("beq_s8", state, 4'd8); chk("beq_pcen", pcen, z[0]);
      chk("beq_pcsrc", pcsrc, 2'b01); chk("beq_alu", alucontrol, 3'b110);
      tick(); chk("beq_s0", state, 4'd0);
    end
    zero = 1'b0;

    op = 6'b101011;
    tick(); chk("sw_s1", state, 4'd1);
    tick(); chk("sw_s2", state, 4'd2); chk("sw_mw2", memwrite, 1'b0);
    tick(); chk("sw_s5", state, 4'd5); chk("sw_mw", {memwrite, iord}, 2'b11);
    tick(); chk("sw_s0", state, 4'd0); chk("sw_mw0", memwrite, 1'b0);

    op = 6'b000010;
    tick(); chk("j_s1", state, 4'd1);
    tick(); chk("j_s11", state, 4'd11); chk("j_pcen", pcen, 1'b1); chk("j_pcsrc", pcsrc, 2'b10);
    tick(); chk("j_s0", state, 4'd0);

    op = 6'b111111;
    tick(); chk("unk_s1", state, 4'd1); chk("unk_wr", {memwrite, regwrite}, 2'b00);
    tick(); chk("unk_s0", state, 4'd0);

    op = 6'b001000;
    tick(); chk("addi_s1", state, 4'd1); chk("noaddi_s1", state0, 4'd1);
    tick(); chk("addi_s9", state, 4'd9); chk("noaddi_s0", state0, 4'd0);
    chk("noaddi_wr", {memwrite0, regwrite0}, 2'b00);
    tick(); chk("addi_s10", state, 4'd10); chk("addi_rw", regwrite, 1'b1);
    reset = 1'b1;
    tick(); reset = 1'b0;

    op = 6'b100011;
    tick(); chk("lwr_s1", state, 4'd1);
    tick(); chk("lwr_s2", state, 4'd2);
    tick(); chk("lwr_s3", state, 4'd3);
    reset = 1'b1; #1;
    chk("lwr_rw_rst", regwrite, 1'b0);
    tick(); reset = 1'b0; #1;
    chk("lwr_s0", state, 4'd0); chk("lwr_rw", regwrite, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_step == 0) begin
        case ($urandom_range(0, 7))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000000;
          3: op = 6'b000100;
          4: op = 6'b001000;
          5: op = 6'b000010;
          6: op = 6'b111111;
          default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0: funct = 6'b100000;
          1: funct = 6'b100010;
          2: funct = 6'b100100;
          3: funct = 6'b100101;
          4: funct = 6'b101010;
          default: funct = 6'($urandom);
        endcase
      end
      zero  = 1'($urandom);
      reset = ($urandom_range(0, 63) == 0);
    end

    tick();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
